// File: rtl/popcnt_accum_if.sv
// popcnt_accum_if -- handshake bundle for the popcount frame accumulator.
//
// Upstream beat stream : in_valid, in_ready, in_count[5:0], in_last
// Downstream result    : out_valid, out_ready, out_sum[SUM_W-1:0],
//                        out_words[WCNT_W-1:0], out_max[5:0], out_err
//
// The slave modport is the accumulator side. The master modport is the side
// that produces beats and consumes results.
interface popcnt_accum_if #(
    parameter int SUM_W  = 16,
    parameter int WCNT_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_count;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_sum;
    logic [WCNT_W-1:0] out_words;
    logic [5:0]        out_max;
    logic              out_err;

    modport master (
        output in_valid, in_count, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_words, out_max, out_err
    );

    modport slave (
        input  in_valid, in_count, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_words, out_max, out_err
    );
endinterface

// File: rtl/popcnt_accum.sv
// popcnt_accum -- accumulates per-word popcounts over a frame of beats and
// presents the frame total, beat count, largest beat and an error flag.
//
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : popcnt_accum_if.slave (beat input stream + result output)
//
// Optional build macro POPCNT_ACCUM_SAT_EN: sum overflow saturates at
// 2^SUM_W-1 and flags an error. Without it the sum wraps silently.
//
// The interface instance must use the same SUM_W/WCNT_W as this module.
module popcnt_accum #(
    parameter int SUM_W  = 16,
    parameter int WCNT_W = 10
) (
    input  logic          clk,
    input  logic          rst,
    popcnt_accum_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [WCNT_W-1:0] words_q, words_d;
    logic [5:0]        max_q, max_d;
    logic              err_q, err_d;

    logic              in_ready_s;
    logic              out_valid_s;
    logic              accept_s;
    logic [5:0]        beat_s;
    logic              illegal_s;
    logic              words_full_s;
`ifdef POPCNT_ACCUM_SAT_EN
    logic [SUM_W:0]    sum_ext_s;
`else
    logic [SUM_W-1:0]  sum_wrap_s;
`endif

    // Illegal counts above one full 32-bit word contribute exactly one word.
    function automatic logic [5:0] clamp_count(input logic [5:0] c);
        return (c > 6'd32) ? 6'd32 : c;
    endfunction

    // State and accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sum_q   <= {SUM_W{1'b0}};
            words_q <= {WCNT_W{1'b0}};
            max_q   <= 6'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            words_q <= words_d;
            max_q   <= max_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs are decoded from the state register only, so in_ready
    // never depends combinationally on in_valid.
    always_comb begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
        case (state_q)
            ST_IDLE:  begin in_ready_s = 1'b1; out_valid_s = 1'b0; end
            ST_ACCUM: begin in_ready_s = 1'b1; out_valid_s = 1'b0; end
            ST_HOLD:  begin in_ready_s = 1'b0; out_valid_s = 1'b1; end
            default:  begin in_ready_s = 1'b1; out_valid_s = 1'b0; end
        endcase
    end

    assign accept_s = bus.in_valid & in_ready_s;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept_s) begin
                    state_d = bus.in_last ? ST_HOLD : ST_ACCUM;
                end else begin
                    state_d = state_q;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Accumulator update: fold accepted beats, freeze in HOLD, clear on release.
    always_comb begin
        sum_d        = sum_q;
        words_d      = words_q;
        max_d        = max_q;
        err_d        = err_q;
        beat_s       = clamp_count(bus.in_count);
        illegal_s    = (bus.in_count > 6'd32);
        words_full_s = (words_q == {WCNT_W{1'b1}});
`ifdef POPCNT_ACCUM_SAT_EN
        sum_ext_s    = {1'b0, sum_q} + {{(SUM_W-5){1'b0}}, beat_s};
`else
        sum_wrap_s   = sum_q + {{(SUM_W-6){1'b0}}, beat_s};
`endif
        if (state_q == ST_HOLD) begin
            if (bus.out_ready) begin
                sum_d   = {SUM_W{1'b0}};
                words_d = {WCNT_W{1'b0}};
                max_d   = 6'd0;
                err_d   = 1'b0;
            end else begin
                sum_d   = sum_q;
            end
        end else if (accept_s) begin
            // The word counter sticks at its ceiling; extra beats only flag.
            if (words_full_s) begin
                words_d = words_q;
            end else begin
                words_d = words_q + {{(WCNT_W-1){1'b0}}, 1'b1};
            end
            max_d = (beat_s > max_q) ? beat_s : max_q;
`ifdef POPCNT_ACCUM_SAT_EN
            if (sum_ext_s[SUM_W]) begin
                sum_d = {SUM_W{1'b1}};
            end else begin
                sum_d = sum_ext_s[SUM_W-1:0];
            end
            err_d = err_q | illegal_s | words_full_s | sum_ext_s[SUM_W];
`else
            sum_d = sum_wrap_s;
            err_d = err_q | illegal_s | words_full_s;
`endif
        end else begin
            sum_d = sum_q;
        end
    end

    // Result fields come straight from the frozen accumulator flops.
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_sum   = sum_q;
    assign bus.out_words = words_q;
    assign bus.out_max   = max_q;
    assign bus.out_err   = err_q;

endmodule

// File: doc/popcnt_accum.md
POPCNT_ACCUM -- requirements
Module: popcnt_accum

Interface
REQ-001 Parameter SUM_W, default 16, width of the frame bit-sum accumulator.
REQ-002 Parameter WCNT_W, default 10, width of the frame word counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream beat valid.
REQ-006 in_ready  output  1  block can accept a beat.
REQ-007 in_count  input  6  per-word popcount, legal range 0..32.
REQ-008 in_last  input  1  final beat of the current frame.
REQ-009 out_valid  output  1  frame result valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_sum  output  SUM_W  total set bits in the frame.
REQ-012 out_words  output  WCNT_W  number of beats in the frame.
REQ-013 out_max  output  6  largest in_count in the frame.
REQ-014 out_err  output  1  frame had an illegal count or overflowed.

Function
REQ-015 The FSM SHALL have three states: IDLE (no beat yet), ACCUM (at least one beat taken, no last), and HOLD (result presented).
REQ-016 A beat SHALL be accepted only when in_valid and in_ready are both 1.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD; it SHALL not depend combinationally on in_valid.
REQ-018 Accepted beat without in_last: sum += in_count, words += 1, max = max(max, in_count); IDLE->ACCUM, ACCUM stays in ACCUM.
REQ-019 Accepted beat with in_last SHALL fold that beat into the totals, move to HOLD, and assert out_valid on the next cycle (1-cycle latency); single-beat frames from IDLE SHALL work identically.
REQ-020 In HOLD, out_sum, out_words, out_max and out_err SHALL stay stable and out_valid SHALL stay 1 until out_ready=1.
REQ-021 HOLD with out_ready=1 SHALL clear all accumulators, deassert out_valid, and move to IDLE next cycle; no beat is accepted in that cycle.
REQ-022 Outside HOLD, out_valid SHALL be 0; the data outputs are don't-care.
REQ-023 in_count > 32 SHALL set the frame error flag, and that beat SHALL add 32 to the sum and max.
REQ-024 A words counter at 2^WCNT_W-1 SHALL hold its value and set the frame error flag on any further accepted beat.
REQ-025 The error flag SHALL be sticky for the frame and clear with the accumulators (REQ-021).
REQ-026 in_valid=0 SHALL leave all state unchanged; frame gaps of any length are legal.

Reset
REQ-027 With rst=1 at a clock edge: state=IDLE, sum=0, words=0, max=0, err=0, out_valid=0, in_ready=1 from the next cycle.
REQ-028 rst SHALL take priority over every handshake; a frame in progress or a held result SHALL be discarded without being presented.

Configuration
REQ-029 With macro POPCNT_ACCUM_SAT_EN defined, a sum overflow SHALL hold the sum at 2^SUM_W-1 and set the frame error flag.
REQ-030 Without POPCNT_ACCUM_SAT_EN, the sum SHALL wrap modulo 2^SUM_W, and overflow SHALL not affect out_err.

Verification
REQ-031 Reset, then beats 5,32,0 with last on 0 -> next cycle out_valid=1, out_sum=37, out_words=3, out_max=32, out_err=0.
REQ-032 Single beat 17 with last, out_ready held 0 for 4 cycles -> out_valid and outputs stable, in_ready=0; out_ready=1 -> IDLE, in_ready=1.
REQ-033 Beat in_count=40 then last 1 -> out_sum=33, out_max=32, out_err=1; next frame 3(last) -> out_err=0.
REQ-034 SUM_W=8, 9 beats of 32 (last on 9th) -> with macro: out_sum=255, out_err=1; without: out_sum=32, out_err=0.
REQ-035 rst asserted mid-frame after beats 10,10 then frame 4(last) -> out_sum=4, out_words=1.
REQ-036 Random in_valid gaps and out_ready backpressure over 1000 frames against a reference model -> no lost or duplicated beats, exact totals.
